// File: rtl/sha2_msg_loader.sv
// Packs a big-endian word stream right-aligned into the SHA-256 plaintext bus and issues a start.
// Optional macro SHA2_LOADER_TIMEOUT_EN adds a WAIT watchdog and a one-cycle `timeout` output.
module sha2_msg_loader #(
    parameter int unsigned MAX_BYTES      = 55,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic [2:0]   s_bytes,
    input  logic         s_last,
    input  logic         hash_done,
    output logic [447:0] plaintext,
    output logic [66:0]  sha2_csr,
    output logic         busy,
    output logic         overflow
`ifdef SHA2_LOADER_TIMEOUT_EN
    ,
    output logic         timeout
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        START,
        WAIT,
        DRAIN
    } state_t;

    localparam logic [6:0] MAX_B = 7'(MAX_BYTES);

    state_t       state_q, state_d;
    logic [447:0] buf_q, buf_d;
    logic [5:0]   cnt_q, cnt_d;
    logic         ovf_q, ovf_d;

    logic         accept;
    logic [2:0]   n;
    logic [447:0] base_buf;
    logic [5:0]   base_cnt;
    logic [6:0]   sum;
    logic [447:0] packed_buf;

`ifdef SHA2_LOADER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tout_q, tout_d;
    assign timeout = tout_q;
`endif

    assign busy      = (state_q == START) || (state_q == WAIT);
    assign s_ready   = ~busy;
    assign overflow  = ovf_q;
    assign plaintext = buf_q;
    assign sha2_csr  = {55'b0, cnt_q, 3'b000, (state_q == START), 2'b00};

    always_comb begin
        accept   = s_valid && s_ready;
        n        = ((s_bytes == 3'd0) || (s_bytes > 3'd4)) ? 3'd4 : s_bytes;
        // A message's first word starts from an empty buffer and zero count.
        base_buf = (state_q == IDLE) ? '0 : buf_q;
        base_cnt = (state_q == IDLE) ? '0 : cnt_q;
        sum      = {1'b0, base_cnt} + {4'b0, n};
        case (n)
            3'd1:    packed_buf = {base_buf[439:0], s_data[31:24]};
            3'd2:    packed_buf = {base_buf[431:0], s_data[31:16]};
            3'd3:    packed_buf = {base_buf[423:0], s_data[31:8]};
            default: packed_buf = {base_buf[415:0], s_data};
        endcase
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
`ifdef SHA2_LOADER_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        tout_d  = 1'b0;
`endif
        case (state_q)
            IDLE, COLLECT: begin
                if (accept) begin
                    if (state_q == IDLE) begin
                        ovf_d = 1'b0;
                    end
                    if (sum > MAX_B) begin
                        buf_d   = base_buf;
                        cnt_d   = base_cnt;
                        ovf_d   = 1'b1;
                        state_d = s_last ? IDLE : DRAIN;
                    end else begin
                        buf_d   = packed_buf;
                        cnt_d   = sum[5:0];
                        state_d = s_last ? START : COLLECT;
                    end
                end
            end
            START: begin
                state_d = WAIT;
`ifdef SHA2_LOADER_TIMEOUT_EN
                tcnt_d  = '0;
`endif
            end
            WAIT: begin
                if (hash_done) begin
                    state_d = IDLE;
                end
`ifdef SHA2_LOADER_TIMEOUT_EN
                else if (tcnt_q == T_LIM) begin
                    state_d = IDLE;
                    tout_d  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
`endif
            end
            DRAIN: begin
                if (accept && s_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef SHA2_LOADER_TIMEOUT_EN
            tcnt_q  <= '0;
            tout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
`ifdef SHA2_LOADER_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
            tout_q  <= tout_d;
`endif
        end
    end

endmodule

// File: tb/tb_sha2_msg_loader.sv
// Directed self-checking bench for sha2_msg_loader; covers the optional watchdog when its macro is defined.
module tb_sha2_msg_loader;

    logic         clock;
    logic         reset_n;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic [2:0]   s_bytes;
    logic         s_last;
    logic         hash_done;
    logic [447:0] plaintext;
    logic [66:0]  sha2_csr;
    logic         busy;
    logic         overflow;
`ifdef SHA2_LOADER_TIMEOUT_EN
    logic         timeout;
`endif

    int checks   = 0;
    int failures = 0;
    int start_cnt = 0;

    sha2_msg_loader #(.MAX_BYTES(55), .TIMEOUT_CYCLES(1024)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_bytes   (s_bytes),
        .s_last    (s_last),
        .hash_done (hash_done),
        .plaintext (plaintext),
        .sha2_csr  (sha2_csr),
        .busy      (busy),
        .overflow  (overflow)
`ifdef SHA2_LOADER_TIMEOUT_EN
        ,
        .timeout   (timeout)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (sha2_csr[2] === 1'b1) start_cnt++;

    task automatic send_word(input logic [31:0] d, input logic [2:0] b, input logic l);
        s_valid = 1'b1; s_data = d; s_bytes = b; s_last = l;
        @(posedge clock); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic pulse_done();
        hash_done = 1'b1;
        @(posedge clock); #1;
        hash_done = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; s_valid = 1'b0; s_data = '0; s_bytes = '0; s_last = 1'b0; hash_done = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (sha2_csr !== 67'd0 || busy !== 1'b0 || overflow !== 1'b0 || plaintext !== 448'd0) begin
            failures++;
            $display("FAIL reset_outputs csr=%h busy=%b ovf=%b pt_nonzero=%b expected all zero",
                     sha2_csr, busy, overflow, |plaintext);
        end
        reset_n = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b expected=1", s_ready);
        end
    endtask

    task automatic test_abc();
        int s0;
        s0 = start_cnt;
        send_word(32'h61626300, 3'd3, 1'b1);
        checks++;
        if (sha2_csr[2] !== 1'b1 || sha2_csr[66:3] !== 64'd24 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abc_start start=%b len=%0d busy=%b expected 1/24/1", sha2_csr[2], sha2_csr[66:3], busy);
        end
        checks++;
        if (plaintext !== 448'h616263) begin
            failures++;
            $display("FAIL abc_plaintext got=%h expected=616263", plaintext[63:0]);
        end
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (sha2_csr[2] !== 1'b0 || sha2_csr[66:3] !== 64'd24 || busy !== 1'b1 || s_ready !== 1'b0
            || start_cnt - s0 !== 1) begin
            failures++;
            $display("FAIL abc_wait start=%b len=%0d busy=%b ready=%b pulses=%0d expected 0/24/1/0/1",
                     sha2_csr[2], sha2_csr[66:3], busy, s_ready, start_cnt - s0);
        end
        pulse_done();
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL abc_done busy=%b ready=%b expected 0/1", busy, s_ready);
        end
    endtask

    task automatic test_max_len();
        logic [447:0] exp;
        int s0;
        s0 = start_cnt;
        exp = '0;
        for (int i = 1; i <= 55; i++) exp[8*(55-i) +: 8] = 8'(i);
        for (int w = 0; w < 13; w++)
            send_word({8'(4*w+1), 8'(4*w+2), 8'(4*w+3), 8'(4*w+4)}, 3'd4, 1'b0);
        send_word({8'd53, 8'd54, 8'd55, 8'hFF}, 3'd3, 1'b1);
        checks++;
        if (sha2_csr[2] !== 1'b1 || sha2_csr[66:3] !== 64'd440 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL max_len start=%b len=%0d ovf=%b expected 1/440/0", sha2_csr[2], sha2_csr[66:3], overflow);
        end
        checks++;
        if (plaintext !== exp) begin
            failures++;
            $display("FAIL max_plaintext low=%h expected low=%h", plaintext[63:0], exp[63:0]);
        end
        @(posedge clock); #1;
        pulse_done();
        checks++;
        if (plaintext !== exp || start_cnt - s0 !== 1) begin
            failures++;
            $display("FAIL max_hold low=%h pulses=%0d expected low=%h pulses=1", plaintext[63:0], start_cnt - s0, exp[63:0]);
        end
    endtask

    task automatic test_overflow_last();
        int s0;
        s0 = start_cnt;
        // s_bytes 0 and 7 both count as 4, so the total is 56 bytes.
        for (int w = 0; w < 13; w++)
            send_word(32'h11223344, (w == 0) ? 3'd0 : ((w == 1) ? 3'd7 : 3'd4), 1'b0);
        checks++;
        if (overflow !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ovf_52 ovf=%b busy=%b expected 0/0", overflow, busy);
        end
        send_word(32'h55667788, 3'd4, 1'b1);
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (overflow !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1 || start_cnt != s0) begin
            failures++;
            $display("FAIL ovf_56 ovf=%b busy=%b ready=%b pulses=%0d expected 1/0/1/0",
                     overflow, busy, s_ready, start_cnt - s0);
        end
        send_word(32'h61626300, 3'd3, 1'b1);
        checks++;
        if (overflow !== 1'b0 || sha2_csr[2] !== 1'b1 || sha2_csr[66:3] !== 64'd24) begin
            failures++;
            $display("FAIL ovf_clear ovf=%b start=%b len=%0d expected 0/1/24", overflow, sha2_csr[2], sha2_csr[66:3]);
        end
        @(posedge clock); #1;
        pulse_done();
    endtask

    task automatic test_drain();
        int s0;
        s0 = start_cnt;
        for (int w = 0; w < 14; w++) send_word(32'hA5A5A5A5, 3'd4, 1'b0);
        checks++;
        if (overflow !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL drain_enter ovf=%b ready=%b busy=%b expected 1/1/0", overflow, s_ready, busy);
        end
        send_word(32'hA5A5A5A5, 3'd4, 1'b1);
        @(posedge clock); #1;
        checks++;
        if (busy !== 1'b0 || start_cnt != s0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL drain_exit busy=%b pulses=%0d ovf=%b expected 0/0/1", busy, start_cnt - s0, overflow);
        end
        send_word(32'h41FFFFFF, 3'd1, 1'b1);
        checks++;
        if (sha2_csr[2] !== 1'b1 || sha2_csr[66:3] !== 64'd8 || plaintext !== 448'h41 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL drain_next start=%b len=%0d pt=%h ovf=%b expected 1/8/41/0",
                     sha2_csr[2], sha2_csr[66:3], plaintext[31:0], overflow);
        end
        @(posedge clock); #1;
        pulse_done();
    endtask

    task automatic test_back_to_back();
        send_word(32'h61626300, 3'd3, 1'b1);
        // In START: keep offering words and assert hash_done early.
        s_valid = 1'b1; s_data = 32'hDEADBEEF; s_bytes = 3'd4; s_last = 1'b1; hash_done = 1'b1;
        @(posedge clock); #1;
        hash_done = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b0 || plaintext !== 448'h616263 || sha2_csr[66:3] !== 64'd24) begin
            failures++;
            $display("FAIL b2b_hold busy=%b ready=%b pt=%h len=%0d expected 1/0/616263/24",
                     busy, s_ready, plaintext[31:0], sha2_csr[66:3]);
        end
        hash_done = 1'b1;
        @(posedge clock); #1;
        hash_done = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b1 || plaintext !== 448'h616263) begin
            failures++;
            $display("FAIL b2b_done busy=%b ready=%b pt=%h expected 0/1/616263", busy, s_ready, plaintext[31:0]);
        end
    endtask

    task automatic test_async_reset();
        send_word(32'h61626300, 3'd3, 1'b1);
        @(posedge clock); #1;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (sha2_csr !== 67'd0 || busy !== 1'b0 || plaintext !== 448'd0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset csr=%h busy=%b pt=%h ready=%b expected 0/0/0/1",
                     sha2_csr, busy, plaintext[31:0], s_ready);
        end
        #2 reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

`ifdef SHA2_LOADER_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        bit seen;
        k = 0; seen = 1'b0;
        send_word(32'h61626300, 3'd3, 1'b1);
        while (!seen && k < 1100) begin
            @(posedge clock); #1;
            k++;
            if (timeout === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || k != 1025 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout seen=%b cycles=%0d busy=%b expected 1/1025/0", seen, k, busy);
        end
        @(posedge clock); #1;
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse got=%b expected=0", timeout);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_abc();
        test_max_len();
        test_overflow_last();
        test_drain();
        test_back_to_back();
        test_async_reset();
`ifdef SHA2_LOADER_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
